pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RV32I core. It merges stall requests from IF, ID, EX and MEM into the 6-bit `stall_o` vector consumed by every pipeline register. It accepts taken jumps/branches from EX, drives the PC redirect, and drives `flush_jump_o` for a fixed kill window. It also tracks stall statistics and raises a sticky watchdog flag on a stuck pipeline.

---
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RV32I pipeline stall/flush/jump controller with stall watchdog
module pipe_ctrl #(
    parameter int ADDR_WIDTH    = 32,
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stallreq_if_i,
    input  logic                  stallreq_id_i,
    input  logic                  stallreq_ex_i,
    input  logic                  stallreq_mem_i,
    input  logic                  jump_req_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic [5:0]            stall_o,
    output logic                  flush_jump_o,
    output logic                  jump_o,
    output logic [ADDR_WIDTH-1:0] jump_addr_o,
    output logic                  stall_timeout_o,
    output logic [31:0]           stall_cnt_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [15:0] RUN_MAX    = 16'(STALL_TIMEOUT);
    localparam logic [15:0] RUN_TRIP   = 16'(STALL_TIMEOUT - 1);

    state_t      state;
    logic [2:0]  fcnt;
    logic [15:0] run_cnt;
    logic        frozen;
    logic        accept;
    logic        id_mask;
    logic        stall_any;

    // Jump acceptance and stall merge; a jump kills the ID instruction and
    // redirects the PC, so ID and IF requests lose to it, while EX/MEM freeze it.
    always_comb begin
        frozen  = stallreq_mem_i | stallreq_ex_i;
        accept  = jump_req_i & ~frozen & (state == IDLE);
        id_mask = accept | (state == FLUSH);
        stall_o = 6'b000000;
        if (stallreq_mem_i) begin
            stall_o = 6'b011111;
        end else if (stallreq_ex_i) begin
            stall_o = 6'b001111;
        end else if (stallreq_id_i && !id_mask) begin
            stall_o = 6'b000111;
        end else if (stallreq_if_i && !accept) begin
            stall_o = 6'b000011;
        end
        stall_any    = |stall_o;
        jump_o       = accept;
        jump_addr_o  = accept ? jump_addr_i : '0;
        flush_jump_o = accept | (state == FLUSH);
    end

    // Flush window: counts down only on cycles the PC actually advances, so
    // a fetch wait inside the window cannot let a wrong-path word slip through.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            fcnt  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && FLUSH_CYCLES > 0) begin
                        state <= FLUSH;
                        fcnt  <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (!stall_o[0]) begin
                        if (fcnt == 3'd1) begin
                            state <= IDLE;
                            fcnt  <= 3'd0;
                        end else begin
                            fcnt <= fcnt - 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    fcnt  <= 3'd0;
                end
            endcase
        end
    end

    // Consecutive-stall watchdog with a sticky trip flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_cnt         <= 16'd0;
            stall_timeout_o <= 1'b0;
        end else if (stall_any) begin
            if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + 16'd1;
            end
            if (run_cnt == RUN_TRIP) begin
                stall_timeout_o <= 1'b1;
            end
        end else begin
            run_cnt <= 16'd0;
        end
    end

    // Total stalled-cycle counter, free-running and wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= 32'd0;
        end else if (stall_any) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stallreq_if_i = 1'b0;
    logic        stallreq_id_i = 1'b0;
    logic        stallreq_ex_i = 1'b0;
    logic        stallreq_mem_i = 1'b0;
    logic        jump_req_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic [5:0]  stall_o;
    logic        flush_jump_o;
    logic        jump_o;
    logic [31:0] jump_addr_o;
    logic        stall_timeout_o;
    logic [31:0] stall_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // {stall, flush, jump, addr}
    logic [39:0] sb_q[$];
    // {stall, timeout, stall_cnt}
    logic [38:0] wd_q[$];

    pipe_ctrl #(
        .ADDR_WIDTH   (32),
        .FLUSH_CYCLES (1),
        .STALL_TIMEOUT(4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stallreq_if_i  (stallreq_if_i),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .jump_req_i     (jump_req_i),
        .jump_addr_i    (jump_addr_i),
        .stall_o        (stall_o),
        .flush_jump_o   (flush_jump_o),
        .jump_o         (jump_o),
        .jump_addr_o    (jump_addr_o),
        .stall_timeout_o(stall_timeout_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    function automatic logic [39:0] mk(input logic [5:0] s, input logic f, input logic j, input logic [31:0] a);
        return {s, f, j, a};
    endfunction

    // stimulus bits: {mem, ex, id, if, jump}
    task automatic drive(input logic [4:0] s, input logic [31:0] a);
        @(posedge clk_i);
        #1;
        stallreq_mem_i = s[4];
        stallreq_ex_i  = s[3];
        stallreq_id_i  = s[2];
        stallreq_if_i  = s[1];
        jump_req_i     = s[0];
        jump_addr_i    = a;
    endtask

    task automatic apply_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        drive_idle_now();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic drive_idle_now();
        stallreq_mem_i = 1'b0;
        stallreq_ex_i  = 1'b0;
        stallreq_id_i  = 1'b0;
        stallreq_if_i  = 1'b0;
        jump_req_i     = 1'b0;
        jump_addr_i    = '0;
    endtask

    task automatic test_reset();
        logic [39:0] got;
        logic [39:0] e;
        rst_i = 1'b1;
        drive_idle_now();
        #12;
        sb_q.push_back(mk(6'b0, 1'b0, 1'b0, 32'h0));
        got = {stall_o, flush_jump_o, jump_o, jump_addr_o};
        e = sb_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required %h", got, e);
        end
        n_cmp++;
        if ({stall_timeout_o, stall_cnt_o} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got to=%b cnt=%0d required to=0 cnt=0", stall_timeout_o, stall_cnt_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_priority();
        logic [4:0]  st [7] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b11110, 5'b01100, 5'b00000};
        logic [5:0]  ex [7] = '{6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b011111, 6'b001111, 6'b000000};
        logic [39:0] got;
        logic [39:0] e;
        for (int i = 0; i < 7; i++) begin
            drive(st[i], 32'hDEAD_0000);
            sb_q.push_back(mk(ex[i], 1'b0, 1'b0, 32'h0));
            #2;
            got = {stall_o, flush_jump_o, jump_o, jump_addr_o};
            e = sb_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL priority step %0d: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_jump();
        logic [4:0]  st [3] = '{5'b00001, 5'b00000, 5'b00000};
        logic [31:0] ad [3] = '{32'h80, 32'h1234, 32'h1234};
        logic [39:0] got;
        logic [39:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(st[i], ad[i]);
            case (i)
                0:       sb_q.push_back(mk(6'b0, 1'b1, 1'b1, 32'h80));
                1:       sb_q.push_back(mk(6'b0, 1'b1, 1'b0, 32'h0));
                default: sb_q.push_back(mk(6'b0, 1'b0, 1'b0, 32'h0));
            endcase
            #2;
            got = {stall_o, flush_jump_o, jump_o, jump_addr_o};
            e = sb_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL jump step %0d: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_jump_frozen();
        logic [4:0]  st [6] = '{5'b10001, 5'b10001, 5'b10001, 5'b00001, 5'b00000, 5'b00000};
        logic [39:0] got;
        logic [39:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(st[i], 32'h200);
            if (i < 3)       sb_q.push_back(mk(6'b011111, 1'b0, 1'b0, 32'h0));
            else if (i == 3) sb_q.push_back(mk(6'b0, 1'b1, 1'b1, 32'h200));
            else if (i == 4) sb_q.push_back(mk(6'b0, 1'b1, 1'b0, 32'h0));
            else             sb_q.push_back(mk(6'b0, 1'b0, 1'b0, 32'h0));
            #2;
            got = {stall_o, flush_jump_o, jump_o, jump_addr_o};
            e = sb_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL jump_frozen step %0d: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_jump_id();
        logic [4:0]  st [4] = '{5'b00101, 5'b00100, 5'b00100, 5'b00000};
        logic [39:0] got;
        logic [39:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(st[i], 32'h44);
            case (i)
                0:       sb_q.push_back(mk(6'b0, 1'b1, 1'b1, 32'h44));
                1:       sb_q.push_back(mk(6'b0, 1'b1, 1'b0, 32'h0));
                2:       sb_q.push_back(mk(6'b000111, 1'b0, 1'b0, 32'h0));
                default: sb_q.push_back(mk(6'b0, 1'b0, 1'b0, 32'h0));
            endcase
            #2;
            got = {stall_o, flush_jump_o, jump_o, jump_addr_o};
            e = sb_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL jump_id step %0d: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_flush_if_stall();
        logic [4:0]  st [5] = '{5'b00011, 5'b00010, 5'b00010, 5'b00001, 5'b00000};
        logic [39:0] got;
        logic [39:0] e;
        for (int i = 0; i < 5; i++) begin
            drive(st[i], 32'h90);
            case (i)
                0:       sb_q.push_back(mk(6'b0, 1'b1, 1'b1, 32'h90));
                1, 2:    sb_q.push_back(mk(6'b000011, 1'b1, 1'b0, 32'h0));
                3:       sb_q.push_back(mk(6'b0, 1'b1, 1'b0, 32'h0));
                default: sb_q.push_back(mk(6'b0, 1'b0, 1'b0, 32'h0));
            endcase
            #2;
            got = {stall_o, flush_jump_o, jump_o, jump_addr_o};
            e = sb_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL flush_if step %0d: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_watchdog_trip();
        logic [38:0] got;
        logic [38:0] e;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive((i < 4) ? 5'b01000 : 5'b00000, 32'h0);
            if (i < 4) wd_q.push_back({6'b001111, 1'b0, 32'(i)});
            else       wd_q.push_back({6'b000000, 1'b1, 32'd4});
            #2;
            got = {stall_o, stall_timeout_o, stall_cnt_o};
            e = wd_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL watchdog_trip step %0d: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_watchdog_short();
        logic [4:0]  st [9] = '{5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b00000};
        logic [31:0] cn [9] = '{0, 1, 2, 3, 3, 4, 5, 6, 6};
        logic [38:0] got;
        logic [38:0] e;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive(st[i], 32'h0);
            wd_q.push_back({st[i][3] ? 6'b001111 : 6'b000000, 1'b0, cn[i]});
            #2;
            got = {stall_o, stall_timeout_o, stall_cnt_o};
            e = wd_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL watchdog_short step %0d: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [39:0] got;
        logic [39:0] e;
        drive(5'b00001, 32'h80);
        sb_q.push_back(mk(6'b0, 1'b1, 1'b1, 32'h80));
        #2;
        got = {stall_o, flush_jump_o, jump_o, jump_addr_o};
        e = sb_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL mid_flush_accept: got %h required %h", got, e);
        end
        drive(5'b00000, 32'h0);
        sb_q.push_back(mk(6'b0, 1'b1, 1'b0, 32'h0));
        #2;
        got = {stall_o, flush_jump_o, jump_o, jump_addr_o};
        e = sb_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL mid_flush_window: got %h required %h", got, e);
        end
        rst_i = 1'b1;
        sb_q.push_back(mk(6'b0, 1'b0, 1'b0, 32'h0));
        #1;
        got = {stall_o, flush_jump_o, jump_o, jump_addr_o};
        e = sb_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL mid_flush_async_reset: got %h required %h", got, e);
        end
        n_cmp++;
        if ({stall_timeout_o, stall_cnt_o} !== 33'd0) begin
            n_fail++;
            $display("FAIL mid_flush_reset_counters: got to=%b cnt=%0d required to=0 cnt=0", stall_timeout_o, stall_cnt_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive(5'b00000, 32'h0);
        sb_q.push_back(mk(6'b0, 1'b0, 1'b0, 32'h0));
        #2;
        got = {stall_o, flush_jump_o, jump_o, jump_addr_o};
        e = sb_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL after_reset_idle: got %h required %h", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_jump();
        test_jump_frozen();
        test_jump_id();
        test_flush_if_stall();
        test_watchdog_trip();
        test_watchdog_short();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
